noc_link_stats: RTL and testbench

- Parametrised, synthesizable NoC link observer; successor to the fixed-size, simulation-only link tracer used in system testbenches.
- Taps valid/ready/last of every link × virtual channel (VC) and keeps per-VC counters:
  - flit count
  - packet count
  - max packet length
  - stall watchdog
- Exposes a registered random-access readout port and sticky stall/length-error flags.
- Sits beside the system NoC, fed from the link_in/link_out handshake wires; usable in testbench and on FPGA.

---
 rtl/noc_link_stats_pkg.sv | 30 +++
 rtl/noc_link_stats_vc.sv | 124 ++++++++++++
 rtl/noc_link_stats.sv | 140 ++++++++++++++
 tb/tb_noc_link_stats.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_link_stats_pkg.sv
// Shared types and helpers for the NoC link statistics observer.
// NOC_LINK_STATS_PROTOCOL_CHECK_EN widens the per-VC flag vector with a protocol-error bit.
package noc_link_stats_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned LEN_W = 8;

`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  localparam int unsigned FLAG_W = 3;
`else
  localparam int unsigned FLAG_W = 2;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StStalled} stall_state_t;

  // Flag layout, LSB first: stall, len_err, proto_err (when enabled).
  typedef struct packed {
    logic [CNT_W-1:0]  flits;
    logic [CNT_W-1:0]  pkts;
    logic [LEN_W-1:0]  maxlen;
    logic [LEN_W-1:0]  curlen;
    logic [CNT_W-1:0]  stall_cnt;
    logic [FLAG_W-1:0] flags;
  } vc_stats_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/noc_link_stats_vc.sv
// Counters, length check and stall watchdog for a single virtual channel.
// NOC_LINK_STATS_PROTOCOL_CHECK_EN adds the valid-drop checker and o_proto_err.
module noc_link_stats_vc
  import noc_link_stats_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned MAX_PKT_LEN   = 16,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_valid,
  input  logic                 i_ready,
  input  logic                 i_last,
  output logic [CNT_WIDTH-1:0] o_flits,
  output logic [CNT_WIDTH-1:0] o_pkts,
  output logic [LEN_WIDTH-1:0] o_maxlen,
  output logic                 o_stall,
  output logic                 o_len_err
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  ,
  output logic                 o_proto_err
`endif
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [31:0] LEN_MAX = 32'((64'd1 << LEN_WIDTH) - 64'd1);
  localparam int unsigned SW = $clog2(STALL_TIMEOUT);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] r_flits, r_pkts, w_flits_inc, w_pkts_inc;
  logic [LEN_WIDTH-1:0] r_maxlen, r_curlen, w_len_inc;
  logic                 r_len_err;
  logic [SW-1:0]        r_stall_cnt, w_stall_cnt_nxt;
  stall_state_t         r_state, w_state_nxt;
  logic                 w_xfer, w_wait;

  assign w_xfer      = i_valid & i_ready;
  assign w_wait      = i_valid & ~i_ready;
  assign w_flits_inc = CNT_WIDTH'(sat_inc(32'(r_flits), CNT_MAX));
  assign w_pkts_inc  = CNT_WIDTH'(sat_inc(32'(r_pkts), CNT_MAX));
  // Length including the flit being transferred now.
  assign w_len_inc   = LEN_WIDTH'(sat_inc(32'(r_curlen), LEN_MAX));

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_wait) begin
          w_state_nxt     = StWait;
          w_stall_cnt_nxt = SW'(1);
        end
      end
      StWait: begin
        if (!w_wait) begin
          w_state_nxt     = StIdle;
          w_stall_cnt_nxt = '0;
        end else if (r_stall_cnt == STALL_LAST) begin
          w_state_nxt = StStalled;
        end else begin
          w_stall_cnt_nxt = r_stall_cnt + SW'(1);
        end
      end
      StStalled: ;
      default: begin
        w_state_nxt     = StIdle;
        w_stall_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state     <= StIdle;
      r_stall_cnt <= '0;
      r_flits     <= '0;
      r_pkts      <= '0;
      r_maxlen    <= '0;
      r_curlen    <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      if (w_xfer) begin
        r_flits <= w_flits_inc;
        if (r_curlen >= LEN_WIDTH'(MAX_PKT_LEN)) r_len_err <= 1'b1;
        if (i_last) begin
          r_pkts   <= w_pkts_inc;
          r_curlen <= '0;
          if (w_len_inc > r_maxlen) r_maxlen <= w_len_inc;
        end else begin
          r_curlen <= w_len_inc;
        end
      end
    end
  end

`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  logic r_pend, r_proto_err;

  // r_pend: valid was offered last cycle without being accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_pend      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_pend <= w_wait;
      if (r_pend && !i_valid) r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;
`endif

  assign o_flits   = r_flits;
  assign o_pkts    = r_pkts;
  assign o_maxlen  = r_maxlen;
  assign o_stall   = (r_state == StStalled);
  assign o_len_err = r_len_err;

endmodule

// File: rtl/noc_link_stats.sv
// NoC link observer: per-VC statistics, registered random-access readout and summary flags.
// NOC_LINK_STATS_PROTOCOL_CHECK_EN adds proto_err to rd_flags and the o_proto_err_any port.
module noc_link_stats
  import noc_link_stats_pkg::*;
#(
  parameter int unsigned LINKS         = 8,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned MAX_PKT_LEN   = 16,
  parameter int unsigned STALL_TIMEOUT = 1024,
  localparam int unsigned NVC = LINKS * CHANNELS,
  localparam int unsigned LW  = (LINKS > 1) ? $clog2(LINKS) : 1,
  localparam int unsigned CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NVC-1:0]       i_valid,
  input  logic [NVC-1:0]       i_ready,
  input  logic [NVC-1:0]       i_last,
  input  logic                 i_clear,
  input  logic                 i_rd_req,
  input  logic [LW-1:0]        i_rd_link,
  input  logic [CW-1:0]        i_rd_chan,
  output logic                 o_rd_valid,
  output logic                 o_rd_err,
  output logic [CNT_WIDTH-1:0] o_rd_flits,
  output logic [CNT_WIDTH-1:0] o_rd_pkts,
  output logic [LEN_WIDTH-1:0] o_rd_maxlen,
  output logic [FLAG_W-1:0]    o_rd_flags,
  output logic                 o_stall_any,
  output logic                 o_err_any
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  ,
  output logic                 o_proto_err_any
`endif
);

  logic [CNT_WIDTH-1:0] w_vc_flits  [NVC];
  logic [CNT_WIDTH-1:0] w_vc_pkts   [NVC];
  logic [LEN_WIDTH-1:0] w_vc_maxlen [NVC];
  logic [FLAG_W-1:0]    w_vc_flags  [NVC];
  logic [NVC-1:0]       w_stall, w_len_err;
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  logic [NVC-1:0]       w_proto;
`endif

  for (genvar g = 0; g < NVC; g++) begin : g_vc
    noc_link_stats_vc #(
      .CNT_WIDTH     (CNT_WIDTH),
      .LEN_WIDTH     (LEN_WIDTH),
      .MAX_PKT_LEN   (MAX_PKT_LEN),
      .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_vc (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (i_clear),
      .i_valid     (i_valid[g]),
      .i_ready     (i_ready[g]),
      .i_last      (i_last[g]),
      .o_flits     (w_vc_flits[g]),
      .o_pkts      (w_vc_pkts[g]),
      .o_maxlen    (w_vc_maxlen[g]),
      .o_stall     (w_stall[g]),
      .o_len_err   (w_len_err[g])
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
      ,
      .o_proto_err (w_proto[g])
`endif
    );
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
    assign w_vc_flags[g] = {w_proto[g], w_len_err[g], w_stall[g]};
`else
    assign w_vc_flags[g] = {w_len_err[g], w_stall[g]};
`endif
  end

  logic [31:0]          w_sel;
  logic                 w_rd_err;
  logic [CNT_WIDTH-1:0] w_rd_flits, w_rd_pkts;
  logic [LEN_WIDTH-1:0] w_rd_maxlen;
  logic [FLAG_W-1:0]    w_rd_flags;

  // Index range check matters only when LINKS/CHANNELS are not powers of two.
  always_comb begin
    w_sel       = 32'(i_rd_link) * CHANNELS + 32'(i_rd_chan);
    w_rd_err    = (32'(i_rd_link) >= LINKS) || (32'(i_rd_chan) >= CHANNELS);
    w_rd_flits  = '0;
    w_rd_pkts   = '0;
    w_rd_maxlen = '0;
    w_rd_flags  = '0;
    if (!w_rd_err) begin
      for (int unsigned i = 0; i < NVC; i++) begin
        if (w_sel == i) begin
          w_rd_flits  = w_vc_flits[i];
          w_rd_pkts   = w_vc_pkts[i];
          w_rd_maxlen = w_vc_maxlen[i];
          w_rd_flags  = w_vc_flags[i];
        end
      end
    end
  end

  // Readout is not affected by clear, so a coincident read returns pre-clear values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_valid  <= 1'b0;
      o_rd_err    <= 1'b0;
      o_rd_flits  <= '0;
      o_rd_pkts   <= '0;
      o_rd_maxlen <= '0;
      o_rd_flags  <= '0;
    end else begin
      o_rd_valid  <= i_rd_req;
      o_rd_err    <= i_rd_req & w_rd_err;
      o_rd_flits  <= i_rd_req ? w_rd_flits : '0;
      o_rd_pkts   <= i_rd_req ? w_rd_pkts : '0;
      o_rd_maxlen <= i_rd_req ? w_rd_maxlen : '0;
      o_rd_flags  <= i_rd_req ? w_rd_flags : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      o_stall_any <= 1'b0;
      o_err_any   <= 1'b0;
    end else begin
      o_stall_any <= |w_stall;
      o_err_any   <= |w_len_err;
    end
  end

`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) o_proto_err_any <= 1'b0;
    else                  o_proto_err_any <= |w_proto;
  end
`endif

endmodule

// File: tb/tb_noc_link_stats.sv
// Randomised and directed bench for noc_link_stats against a per-VC behavioural model.
// Honours NOC_LINK_STATS_PROTOCOL_CHECK_EN for the extra flag bit and port.
module tb_noc_link_stats;
  import noc_link_stats_pkg::*;

  localparam int unsigned LINKS         = 3;
  localparam int unsigned CHANNELS      = 2;
  localparam int unsigned CNT_WIDTH     = 4;
  localparam int unsigned LEN_WIDTH     = 4;
  localparam int unsigned MAX_PKT_LEN   = 4;
  localparam int unsigned STALL_TIMEOUT = 8;
  localparam int unsigned NVC           = LINKS * CHANNELS;
  localparam int unsigned CMAX          = (1 << CNT_WIDTH) - 1;
  localparam int unsigned LMAX          = (1 << LEN_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst, clear, rd_req;
  logic [NVC-1:0]       valid, ready, last;
  logic [1:0]           rd_link;
  logic [0:0]           rd_chan;
  logic                 rd_valid, rd_err, stall_any, err_any;
  logic [CNT_WIDTH-1:0] rd_flits, rd_pkts;
  logic [LEN_WIDTH-1:0] rd_maxlen;
  logic [FLAG_W-1:0]    rd_flags;
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
  logic                 proto_err_any;
`endif

  always #5 clk = ~clk;

  noc_link_stats #(
    .LINKS         (LINKS),
    .CHANNELS      (CHANNELS),
    .CNT_WIDTH     (CNT_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .MAX_PKT_LEN   (MAX_PKT_LEN),
    .STALL_TIMEOUT (STALL_TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_ready     (ready),
    .i_last      (last),
    .i_clear     (clear),
    .i_rd_req    (rd_req),
    .i_rd_link   (rd_link),
    .i_rd_chan   (rd_chan),
    .o_rd_valid  (rd_valid),
    .o_rd_err    (rd_err),
    .o_rd_flits  (rd_flits),
    .o_rd_pkts   (rd_pkts),
    .o_rd_maxlen (rd_maxlen),
    .o_rd_flags  (rd_flags),
    .o_stall_any (stall_any),
    .o_err_any   (err_any)
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
    ,
    .o_proto_err_any (proto_err_any)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_miscmp = 0;

  // Model state: stall_cnt holds the current run of valid&!ready cycles.
  vc_stats_t mdl [NVC];
  bit        m_pend [NVC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int unsigned i);
    int unsigned len;
    if (valid[i] && ready[i]) begin
      if (mdl[i].flits < CMAX) mdl[i].flits = mdl[i].flits + 1;
      if (int'(mdl[i].curlen) + 1 > int'(MAX_PKT_LEN)) mdl[i].flags[1] = 1'b1;
      len = (mdl[i].curlen + 1 > LMAX) ? LMAX : mdl[i].curlen + 1;
      if (last[i]) begin
        if (mdl[i].pkts < CMAX) mdl[i].pkts = mdl[i].pkts + 1;
        if (len > mdl[i].maxlen) mdl[i].maxlen = LEN_W'(len);
        mdl[i].curlen = '0;
      end else begin
        mdl[i].curlen = LEN_W'(len);
      end
    end
    if (valid[i] && !ready[i]) begin
      mdl[i].stall_cnt = mdl[i].stall_cnt + 1;
      if (mdl[i].stall_cnt >= STALL_TIMEOUT) mdl[i].flags[0] = 1'b1;
    end else begin
      mdl[i].stall_cnt = '0;
    end
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
    if (m_pend[i] && !valid[i]) mdl[i].flags[2] = 1'b1;
`endif
    m_pend[i] = valid[i] && !ready[i];
  endtask

  // Apply current inputs for one clock and check everything registered at that edge.
  task automatic tick();
    bit          oor, e_v, e_e, e_sa, e_ea, e_pa;
    int unsigned sel;
    logic [31:0] e_fl, e_pk, e_ml;
    logic [FLAG_W-1:0] e_fg;
    oor  = (rd_link >= LINKS) || (rd_chan >= CHANNELS);
    sel  = rd_link * CHANNELS + rd_chan;
    e_v  = rd_req;
    e_e  = rd_req && oor;
    e_fl = 0; e_pk = 0; e_ml = 0; e_fg = '0;
    if (rd_req && !oor) begin
      e_fl = mdl[sel].flits;
      e_pk = mdl[sel].pkts;
      e_ml = 32'(mdl[sel].maxlen);
      e_fg = mdl[sel].flags;
    end
    e_sa = 0; e_ea = 0; e_pa = 0;
    for (int unsigned i = 0; i < NVC; i++) begin
      e_sa |= mdl[i].flags[0];
      e_ea |= mdl[i].flags[1];
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
      e_pa |= mdl[i].flags[2];
`endif
    end
    if (clear || rst) begin e_sa = 0; e_ea = 0; e_pa = 0; end
    if (rst) begin
      e_v = 0; e_e = 0; e_fl = 0; e_pk = 0; e_ml = 0; e_fg = '0;
    end
    for (int unsigned i = 0; i < NVC; i++) begin
      if (rst || clear) begin
        mdl[i]    = '0;
        m_pend[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, e_v);
    if (rd_req || rst) begin
      chk("rd_err", rd_err, e_e);
      chk("rd_flits", rd_flits, e_fl);
      chk("rd_pkts", rd_pkts, e_pk);
      chk("rd_maxlen", rd_maxlen, e_ml);
      chk("rd_flags", rd_flags, e_fg);
    end
    chk("stall_any", stall_any, e_sa);
    chk("err_any", err_any, e_ea);
`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
    chk("proto_err_any", proto_err_any, e_pa);
`endif
  endtask

  task automatic quiet();
    valid = '0; ready = '0; last = '0; rd_req = 0; clear = 0; rst = 0;
  endtask

  task automatic send(input int unsigned vc, input bit is_last);
    valid = '0; ready = '0; last = '0;
    valid[vc] = 1'b1; ready[vc] = 1'b1; last[vc] = is_last;
    tick();
  endtask

  task automatic hold(input int unsigned vc, input int unsigned n);
    valid = '0; ready = '0; last = '0;
    valid[vc] = 1'b1;
    repeat (n) tick();
  endtask

  task automatic rd(input int unsigned l, input int unsigned c);
    rd_req = 1; rd_link = 2'(l); rd_chan = 1'(c);
    tick();
    rd_req = 0;
  endtask

  initial begin
    quiet();
    rd_link = '0; rd_chan = '0;
    for (int unsigned i = 0; i < NVC; i++) begin mdl[i] = '0; m_pend[i] = 0; end
    rst = 1; tick(); rst = 1; rd_req = 1; tick(); quiet();
    chk("reset_rd_valid", rd_valid, 0);

    // Three 4-flit packets on link1/VC0.
    for (int p = 0; p < 3; p++) for (int f = 0; f < 4; f++) send(2, f == 3);
    quiet(); rd(1, 0);
    chk("l1c0_flits", rd_flits, 12);
    chk("l1c0_pkts", rd_pkts, 3);
    chk("l1c0_maxlen", rd_maxlen, 4);
    chk("l1c0_flags", rd_flags, 0);
    rd(0, 0);
    chk("l0c0_flits", rd_flits, 0);

    // Stall: 7 blocked cycles do not trip, 8 do and stay sticky.
    hold(1, 7); send(1, 1); quiet(); rd(0, 1);
    chk("stall7_flag", rd_flags[0], 0);
    hold(1, 8);
    chk("stall8_any_early", stall_any, 0);
    send(1, 1);
    chk("stall8_any", stall_any, 1);
    quiet(); tick(); rd(0, 1);
    chk("stall8_flag", rd_flags[0], 1);
    chk("stall8_sticky", stall_any, 1);

    // Length error on the 5th flit of a 6-flit packet on link2/VC0.
    quiet(); clear = 1; tick(); clear = 0;
    for (int f = 0; f < 4; f++) send(4, 0);
    rd_req = 1; rd_link = 2; rd_chan = 0; send(4, 0);
    chk("len_flit4", rd_flags[1], 0);
    send(4, 1);
    chk("len_flit5", rd_flags[1], 1);
    quiet(); rd(2, 0);
    chk("len_maxlen", rd_maxlen, 6);
    chk("len_err_any", err_any, 1);

    // Counter saturation on link2/VC1.
    clear = 1; tick(); clear = 0;
    for (int p = 0; p < 20; p++) send(5, 1);
    quiet(); rd(2, 1);
    chk("sat_flits", rd_flits, 15);
    chk("sat_pkts", rd_pkts, 15);

    // Clear together with read and a transfer.
    clear = 1; tick(); clear = 0;
    for (int f = 0; f < 5; f++) send(0, 0);
    clear = 1; rd_req = 1; rd_link = 0; rd_chan = 0; send(0, 0);
    chk("clear_read_pre", rd_flits, 5);
    quiet(); rd(0, 0);
    chk("clear_read_post", rd_flits, 0);

    // Out-of-range link.
    rd(3, 0);
    chk("oor_valid", rd_valid, 1);
    chk("oor_err", rd_err, 1);
    chk("oor_flits", rd_flits, 0);

`ifdef NOC_LINK_STATS_PROTOCOL_CHECK_EN
    hold(3, 1); quiet(); tick(); rd(1, 1);
    chk("proto_flag", rd_flags[2], 1);
    chk("proto_any", proto_err_any, 1);
`endif

    // Random traffic in alternating flowing and starved phases.
    for (int n = 0; n < 3000; n++) begin
      bit starve;
      starve = ((n / 200) % 2) == 1;
      for (int unsigned i = 0; i < NVC; i++) begin
        valid[i] = $urandom_range(0, 3) != 0;
        ready[i] = starve ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) != 0);
        last[i]  = $urandom_range(0, 3) == 0;
      end
      rd_req  = $urandom_range(0, 1) == 1;
      rd_link = 2'($urandom_range(0, 3));
      rd_chan = 1'($urandom_range(0, 1));
      clear   = $urandom_range(0, 149) == 0;
      rst     = (n == 1500);
      tick();
    end
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
